// File: rtl/dac_serial_tx.sv
// Serialises a registered DDS sample into a 3-wire DAC frame (MSB first, zero padded),
// with a divided SCLK and a request/busy/done handshake to the sample source.
module dac_serial_tx #(
    parameter int DATA_W     = 10,
    parameter int FRAME_BITS = 12,
    parameter int CLK_DIV    = 4,
    parameter int CS_HIGH    = 8,
    parameter int AUTO       = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] wavevalue,
    input  logic              sample_req,
    output logic              busy,
    output logic              done,
    output logic              dac_cs_n,
    output logic              dac_sclk,
    output logic              dac_din
);

    localparam int             BCW       = $clog2(FRAME_BITS + 1);
    localparam logic [7:0]     DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [7:0]     HOLD_LAST = 8'(CS_HIGH);
    localparam logic [BCW-1:0] BITS_LAST = BCW'(FRAME_BITS);
    localparam bit             AUTO_EN   = (AUTO != 0);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    state_t                state_q, state_d;
    logic [FRAME_BITS-1:0] shreg_q, shreg_d;
    logic [7:0]            div_q, div_d;
    logic [BCW-1:0]        bit_q, bit_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  cs_n_q, cs_n_d;
    logic                  sclk_q, sclk_d;
    logic                  din_q, din_d;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        div_d   = div_q;
        bit_d   = bit_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cs_n_d  = cs_n_q;
        sclk_d  = sclk_q;
        din_d   = din_q;

        case (state_q)
            IDLE: begin
                if (sample_req || AUTO_EN) begin
                    shreg_d = '0;
                    shreg_d[FRAME_BITS-1 -: DATA_W] = wavevalue;
                    busy_d  = 1'b1;
                    cs_n_d  = 1'b0;
                    sclk_d  = 1'b0;
                    din_d   = wavevalue[DATA_W-1];
                    div_d   = '0;
                    bit_d   = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    sclk_d  = 1'b1;
                    bit_d   = bit_q + BCW'(1);
                    state_d = SHIFT;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                        // Frame ends on the falling edge after the last rising edge.
                        if (bit_q == BITS_LAST) begin
                            cs_n_d  = 1'b1;
                            din_d   = 1'b0;
                            state_d = HOLD;
                        end else begin
                            shreg_d = {shreg_q[FRAME_BITS-2:0], 1'b0};
                            din_d   = shreg_q[FRAME_BITS-2];
                        end
                    end else begin
                        sclk_d = 1'b1;
                        bit_d  = bit_q + BCW'(1);
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            HOLD: begin
                // CS_HIGH cycles of CS_n high plus the cycle that registers done.
                if (div_q == HOLD_LAST) begin
                    div_d   = '0;
                    bit_d   = '0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b0;
            din_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cs_n_q  <= cs_n_d;
            sclk_q  <= sclk_d;
            din_q   <= din_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign dac_cs_n = cs_n_q;
    assign dac_sclk = sclk_q;
    assign dac_din  = din_q;

endmodule

// File: tb/tb_dac_serial_tx.sv
// Directed bench for dac_serial_tx: default instance for handshake/frame checks,
// second instance in free-running mode with fastest timing.
module tb_dac_serial_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] wavevalue = '0;
    logic       sample_req = 1'b0;
    logic       busy, done, dac_cs_n, dac_sclk, dac_din;

    logic       rst_b_n = 1'b0;
    logic [9:0] wavevalue_b = 10'h155;
    logic       sample_req_b = 1'b0;
    logic       busy_b, done_b, cs_n_b, sclk_b, din_b;

    always #5 clk = ~clk;

    dac_serial_tx #(.DATA_W(10), .FRAME_BITS(12), .CLK_DIV(4), .CS_HIGH(8), .AUTO(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .wavevalue(wavevalue), .sample_req(sample_req),
        .busy(busy), .done(done), .dac_cs_n(dac_cs_n), .dac_sclk(dac_sclk), .dac_din(dac_din)
    );

    dac_serial_tx #(.DATA_W(10), .FRAME_BITS(12), .CLK_DIV(1), .CS_HIGH(1), .AUTO(1)) u_auto (
        .clk(clk), .rst_n(rst_b_n), .wavevalue(wavevalue_b), .sample_req(sample_req_b),
        .busy(busy_b), .done(done_b), .dac_cs_n(cs_n_b), .dac_sclk(sclk_b), .dac_din(din_b)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    // Monitor for the default instance.
    int          rise_a = 0, done_cnt = 0, done_cyc = 0, fall_cyc = 0, fall_cnt = 0;
    int          cs_rise_cyc = 0, run_a = 0, phases = 0, bad_phase = 0;
    logic [11:0] word_a = '0;
    logic        prev_sclk_a = 1'b0, prev_cs_a = 1'b1;

    always @(negedge clk) begin
        if (dac_sclk && !prev_sclk_a) begin
            rise_a++;
            word_a = {word_a[10:0], dac_din};
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (!dac_cs_n && prev_cs_a) begin
            fall_cnt++;
            fall_cyc = cyc;
        end
        if (dac_cs_n && !prev_cs_a) cs_rise_cyc = cyc;
        if (dac_cs_n) run_a = 0;
        else if (dac_sclk == prev_sclk_a || run_a == 0) run_a++;
        else begin
            phases++;
            if (run_a != 4) bad_phase++;
            run_a = 1;
        end
        prev_sclk_a = dac_sclk;
        prev_cs_a   = dac_cs_n;
    end

    // Monitor for the free-running instance: each frame is verified when the next one starts.
    int          fall_cnt_b = 0, last_fall_b = 0, bad_period_b = 0, bad_frame_b = 0, rise_since_b = 0;
    logic [11:0] word_b = '0;
    logic        prev_sclk_b = 1'b0, prev_cs_b = 1'b1;

    always @(negedge clk) begin
        if (sclk_b && !prev_sclk_b) begin
            rise_since_b++;
            word_b = {word_b[10:0], din_b};
        end
        if (!cs_n_b && prev_cs_b) begin
            if (fall_cnt_b > 0) begin
                if (cyc - last_fall_b != 27) bad_period_b++;
                if (rise_since_b != 12 || word_b != 12'h554) bad_frame_b++;
            end
            fall_cnt_b++;
            last_fall_b  = cyc;
            rise_since_b = 0;
        end
        prev_sclk_b = sclk_b;
        prev_cs_b   = cs_n_b;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_done(input string tag);
        int start;
        int i;
        start = done_cnt;
        i = 0;
        while (done_cnt == start && i < 300) begin
            step();
            i++;
        end
        chk(tag, done_cnt - start, 1);
    endtask

    int r0, d0, f0, bad_idle;

    initial begin
        // Reset state
        step(3);
        chk("rst_cs_n", dac_cs_n, 1);
        chk("rst_sclk", dac_sclk, 0);
        chk("rst_din", dac_din, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;
        step(3);

        // Single frame 0x2AB
        r0 = rise_a;
        wavevalue = 10'h2AB;
        sample_req = 1'b1;
        step();
        sample_req = 1'b0;
        chk("f1_cs_low", dac_cs_n, 0);
        chk("f1_busy", busy, 1);
        wait_done("f1_done_seen");
        chk("f1_rises", rise_a - r0, 12);
        chk("f1_bits", word_a, 12'hAAC);
        chk("f1_period", done_cyc - fall_cyc, 105);
        chk("f1_busy_at_done", busy, 0);
        step();
        chk("f1_done_width", done, 0);
        chk("f1_sclk_phases", bad_phase, 0);

        // Back-to-back 0x3FF then 0x000 with request held through done
        step(5);
        wavevalue = 10'h3FF;
        sample_req = 1'b1;
        step();
        wavevalue = 10'h000;
        r0 = rise_a;
        wait_done("f2_done_seen");
        chk("f2_bits", word_a, 12'hFFC);
        chk("f2_rises", rise_a - r0, 12);
        r0 = rise_a;
        d0 = done_cyc;
        step();
        sample_req = 1'b0;
        chk("f3_cs_low", dac_cs_n, 0);
        chk("f3_handoff", fall_cyc - d0, 1);
        chk("f3_cs_high_gap", fall_cyc - cs_rise_cyc, 10);
        wait_done("f3_done_seen");
        chk("f3_bits", word_a, 12'h000);
        chk("f3_rises", rise_a - r0, 12);
        chk("f3_period", done_cyc - fall_cyc, 105);

        // Requests and data changes during a frame are ignored
        step(4);
        r0 = rise_a;
        f0 = fall_cnt;
        wavevalue = 10'h1C3;
        sample_req = 1'b1;
        step();
        sample_req = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step(9);
            wavevalue = 10'($urandom);
            sample_req = 1'b1;
            step();
            sample_req = 1'b0;
        end
        wait_done("f4_done_seen");
        chk("f4_bits", word_a, 12'h70C);
        chk("f4_rises", rise_a - r0, 12);
        d0 = done_cnt;
        step(150);
        chk("f4_single_done", done_cnt - d0, 0);
        chk("f4_single_frame", fall_cnt - f0, 1);

        // Asynchronous reset mid-shift
        wavevalue = 10'h2AB;
        sample_req = 1'b1;
        step();
        sample_req = 1'b0;
        step(50);
        d0 = done_cnt;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_cs_n", dac_cs_n, 1);
        chk("arst_sclk", dac_sclk, 0);
        chk("arst_busy", busy, 0);
        chk("arst_din", dac_din, 0);
        step(3);
        rst_n = 1'b1;
        step(150);
        chk("arst_no_done", done_cnt - d0, 0);
        r0 = rise_a;
        wavevalue = 10'h0F0;
        sample_req = 1'b1;
        step();
        sample_req = 1'b0;
        wait_done("f5_done_seen");
        chk("f5_bits", word_a, 12'h3C0);
        chk("f5_rises", rise_a - r0, 12);
        chk("f5_period", done_cyc - fall_cyc, 105);
        chk("all_sclk_phases", bad_phase, 0);

        // Idle for 1000 cycles
        bad_idle = 0;
        d0 = done_cnt;
        step();
        for (int k = 0; k < 1000; k++) begin
            if (dac_cs_n !== 1'b1 || dac_sclk !== 1'b0 || dac_din !== 1'b0 ||
                busy !== 1'b0 || done !== 1'b0) bad_idle++;
            step();
        end
        chk("idle_outputs", bad_idle, 0);
        chk("idle_no_done", done_cnt - d0, 0);

        // Free-running instance
        rst_b_n = 1'b1;
        step(300);
        chk("auto_frames", fall_cnt_b >= 10, 1);
        chk("auto_period", bad_period_b, 0);
        chk("auto_bits", bad_frame_b, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
